// File: rtl/mdx_pkg.sv
// rtl/mdx_pkg.sv - shared types for mont_domain_xfer; MDX_RADIX4_EN selects two lane steps per clock
package mdx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdx_state_e;

`ifdef MDX_RADIX4_EN
    localparam int STEPS_PER_CYC = 2;
`else
    localparam int STEPS_PER_CYC = 1;
`endif

    function automatic int mdx_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mdx_lane.sv
// rtl/mdx_lane.sv - one coordinate lane: modular double (x*2) or halve (x/2) steps modulo an odd prime
module mdx_lane
    import mdx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = STEPS_PER_CYC
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             to_mont,
    input  logic [WIDTH-1:0] prime,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] nxt;

    // Halving adds p to odd values first; p odd makes the sum even so the shift is exact.
    function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] p,
                                                  input logic             dbl);
        logic [WIDTH:0] t;
        if (dbl) begin
            t = {x, 1'b0};
            if (t >= {1'b0, p})
                t = t - {1'b0, p};
            return t[WIDTH-1:0];
        end else begin
            t = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
            return t[WIDTH:1];
        end
    endfunction

    always_comb begin
        nxt = q;
        for (int i = 0; i < STEPS; i++)
            nxt = mod_step(nxt, prime, to_mont);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= din;
        else if (en)
            q <= nxt;
    end

endmodule

// File: rtl/mont_domain_xfer.sv
// rtl/mont_domain_xfer.sv - point (Px,Py) into/out of Montgomery domain, R = 2^WIDTH; MDX_RADIX4_EN halves RUN length
module mont_domain_xfer
    import mdx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = mdx_cnt_w(WIDTH)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_sig,
    input  logic             ToMont,
    input  logic [WIDTH-1:0] Px_i,
    input  logic [WIDTH-1:0] Py_i,
    input  logic [WIDTH-1:0] Prime,
    output logic [WIDTH-1:0] Px_out,
    output logic [WIDTH-1:0] Py_out,
    output logic             done,
    output logic             busy
);

    mdx_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] prime_q;
    logic             mode_q;
    logic             start;
    logic             run;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;

    assign start    = (state == IDLE) && in_sig;
    assign run      = (state == RUN);
    assign cnt_next = cnt + CNT_W'(STEPS_PER_CYC);

    mdx_lane #(.WIDTH(WIDTH), .STEPS(STEPS_PER_CYC)) u_lane_x (
        .clk     (clk),
        .reset   (reset),
        .load    (start),
        .en      (run),
        .to_mont (mode_q),
        .prime   (prime_q),
        .din     (Px_i),
        .q       (x_q)
    );

    mdx_lane #(.WIDTH(WIDTH), .STEPS(STEPS_PER_CYC)) u_lane_y (
        .clk     (clk),
        .reset   (reset),
        .load    (start),
        .en      (run),
        .to_mont (mode_q),
        .prime   (prime_q),
        .din     (Py_i),
        .q       (y_q)
    );

    // busy trails the state by one edge so it covers the done cycle but not the start cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            prime_q <= '0;
            mode_q  <= 1'b0;
            Px_out  <= '0;
            Py_out  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= (state == DONE);
            busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (in_sig) begin
                        prime_q <= Prime;
                        mode_q  <= ToMont;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt_next;
                    // >= rather than == so a misconfigured odd WIDTH cannot lock the FSM in RUN
                    if (cnt_next >= CNT_W'(WIDTH))
                        state <= DONE;
                end
                DONE: begin
                    Px_out <= x_q;
                    Py_out <= y_q;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_domain_xfer.sv
// tb/tb_mont_domain_xfer.sv - self-checking bench for mont_domain_xfer (WIDTH=32 and WIDTH=8 instances)
module tb_mont_domain_xfer;

`ifdef MDX_RADIX4_EN
    localparam int LAT32 = 32 / 2 + 2;
    localparam int LAT8  = 8 / 2 + 2;
`else
    localparam int LAT32 = 32 + 2;
    localparam int LAT8  = 8 + 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_sig;
    logic        ToMont;
    logic [31:0] Px_i, Py_i, Prime;
    logic [31:0] Px_out, Py_out;
    logic        done, busy;

    logic        in_sig8;
    logic        ToMont8;
    logic [7:0]  Px8, Py8, Prime8;
    logic [7:0]  Px8_out, Py8_out;
    logic        done8, busy8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mont_domain_xfer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_sig(in_sig), .ToMont(ToMont),
        .Px_i(Px_i), .Py_i(Py_i), .Prime(Prime),
        .Px_out(Px_out), .Py_out(Py_out), .done(done), .busy(busy)
    );

    mont_domain_xfer #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_sig(in_sig8), .ToMont(ToMont8),
        .Px_i(Px8), .Py_i(Py8), .Prime(Prime8),
        .Px_out(Px8_out), .Py_out(Py8_out), .done(done8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: x*R mod p and x*R^-1 mod p with R = 2^32, via plain arithmetic.
    function automatic longint modinv(input longint a, input longint m);
        longint r0, r1, s0, s1, q, tmp;
        r0 = m; r1 = a; s0 = 0; s1 = 1;
        while (r1 != 0) begin
            q = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = s0 - q * s1; s0 = s1; s1 = tmp;
        end
        if (s0 < 0) s0 = s0 + m;
        return s0;
    endfunction

    function automatic logic [31:0] ref_conv(input logic m, input logic [31:0] x, input logic [31:0] p);
        longint unsigned lx, lp, inv;
        lx = {32'd0, x};
        lp = {32'd0, p};
        if (m)
            return 32'((lx << 32) % lp);
        inv = longint'(modinv(longint'((64'd1 << 32) % lp), longint'(lp)));
        return 32'((lx * inv) % lp);
    endfunction

    task automatic start(input logic m, input logic [31:0] x, input logic [31:0] y, input logic [31:0] p);
        ToMont = m; Px_i = x; Py_i = y; Prime = p; in_sig = 1'b1;
        @(posedge clk);
        #1;
        in_sig = 1'b0;
        Px_i = $urandom; Py_i = $urandom; Prime = $urandom; ToMont = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0; busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end while (!done && lat < 200);
        if (!done) begin
            failures++; checks++;
            $display("FAIL timeout: no done within %0d cycles", lat);
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] p, input logic [31:0] ex, input logic [31:0] ey);
        int lat, bc;
        start(m, x, y, p);
        wait_done(lat, bc);
        check({tag, "_px"}, 64'(Px_out), 64'(ex));
        check({tag, "_py"}, 64'(Py_out), 64'(ey));
        check({tag, "_lat"}, 64'(lat), 64'(LAT32));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, bc, ndone;
        logic [31:0] p, x, y, ex, ey;
        logic m;

        reset = 1'b1; in_sig = 1'b0; ToMont = 1'b0; Px_i = '0; Py_i = '0; Prime = '0;
        in_sig8 = 1'b0; ToMont8 = 1'b0; Px8 = '0; Py8 = '0; Prime8 = '0;
        repeat (3) @(negedge clk);
        check("rst_px", 64'(Px_out), 64'd0);
        check("rst_py", 64'(Py_out), 64'd0);
        check("rst_done_busy", {62'd0, done, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors with latency and busy-length checks
        start(1'b1, 32'd1, 32'd2, 32'hFFFF_FFFB);
        wait_done(lat, bc);
        check("tm1_px", 64'(Px_out), 64'h5);
        check("tm1_py", 64'(Py_out), 64'hA);
        check("tm1_lat", 64'(lat), 64'(LAT32));
        check("tm1_busy", 64'(bc), 64'(LAT32 - 1));
        @(negedge clk);
        check("tm1_done_low", 64'(done), 64'd0);
        check("tm1_busy_low", 64'(busy), 64'd0);

        run_op("fm1", 1'b0, 32'h5, 32'hFFFF_FFF6, 32'hFFFF_FFFB, 32'h1, 32'hFFFF_FFFA);
        run_op("p7_to", 1'b1, 32'd3, 32'd0, 32'd7, 32'd5, 32'd0);
        run_op("p7_back", 1'b0, 32'd5, 32'd0, 32'd7, 32'd3, 32'd0);

        // Extra start pulses while busy are dropped
        start(1'b1, 32'd7, 32'd9, 32'd1_000_003);
        ndone = 0;
        for (int k = 1; k <= 2 * LAT32; k++) begin
            in_sig = (k == 5 || k == 20);
            @(negedge clk);
            if (done) begin
                ndone++;
                check("ign_px", 64'(Px_out), 64'(ref_conv(1'b1, 32'd7, 32'd1_000_003)));
                check("ign_py", 64'(Py_out), 64'(ref_conv(1'b1, 32'd9, 32'd1_000_003)));
            end
        end
        in_sig = 1'b0;
        check("ign_ndone", 64'(ndone), 64'd1);

        // Back-to-back: restart issued in the done cycle
        start(1'b1, 32'd11, 32'd12, 32'd13);
        wait_done(lat, bc);
        check("b2b_first_px", 64'(Px_out), 64'(ref_conv(1'b1, 32'd11, 32'd13)));
        start(1'b0, 32'd11, 32'd12, 32'd13);
        wait_done(lat, bc);
        check("b2b_second_px", 64'(Px_out), 64'(ref_conv(1'b0, 32'd11, 32'd13)));
        check("b2b_second_py", 64'(Py_out), 64'(ref_conv(1'b0, 32'd12, 32'd13)));
        check("b2b_lat", 64'(lat), 64'(LAT32));
        @(negedge clk);

        // Asynchronous reset mid-RUN
        start(1'b1, 32'h1234, 32'h55, 32'hFFFF_FFFB);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_px", 64'(Px_out), 64'd0);
        check("arst_py", 64'(Py_out), 64'd0);
        check("arst_done_busy", {62'd0, done, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 2 * LAT32; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_no_done", 64'(ndone), 64'd0);
        run_op("arst_fresh", 1'b1, 32'h1234, 32'h55, 32'hFFFF_FFFB,
               ref_conv(1'b1, 32'h1234, 32'hFFFF_FFFB), ref_conv(1'b1, 32'h55, 32'hFFFF_FFFB));

        // Randomised operations against the arithmetic reference
        for (int n = 0; n < 24; n++) begin
            p = $urandom | 32'd1;
            if (p < 32'd3) p = 32'd3;
            if (n % 6 == 5) p = 32'd3 + 32'($urandom_range(0, 40)) * 2;
            x = (n % 5 == 0) ? 32'd0 : $urandom % p;
            y = $urandom % p;
            m = 1'($urandom);
            ex = ref_conv(m, x, p);
            ey = ref_conv(m, y, p);
            run_op($sformatf("rnd%0d", n), m, x, y, p, ex, ey);
        end

        // WIDTH=8 instance: 1*256 mod 251 = 5
        ToMont8 = 1'b1; Px8 = 8'd1; Py8 = 8'd250; Prime8 = 8'd251; in_sig8 = 1'b1;
        @(posedge clk);
        #1 in_sig8 = 1'b0; Px8 = 8'hAA; Prime8 = 8'h10;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done8 && lat < 100);
        check("w8_px", 64'(Px8_out), 64'd5);
        check("w8_py", 64'(Py8_out), 64'd246);
        check("w8_lat", 64'(lat), 64'(LAT8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mont_domain_xfer.md
Name: mont_domain_xfer

Overview:
- Parametrised successor to the 32-bit Domain_Transfer block.
- Converts an elliptic-curve point (Px, Py) into or out of the Montgomery domain modulo an odd prime. The Montgomery radix is R = 2^WIDTH.
  - To-Montgomery: x·R mod p.
  - From-Montgomery: x·R⁻¹ mod p.
- Sits between the ECC top-level loader and the point-arithmetic core. Both coordinates are processed in parallel by iterative modular doubling/halving, so no multiplier is needed.

Parameters:
- WIDTH, 32, operand/prime width in bits. Must be ≥ 4, and even when MDX_RADIX4_EN is defined.
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_sig  in  1  start pulse; sampled only in IDLE.
- ToMont  in  1  1 = to Montgomery domain (×R); 0 = from Montgomery domain (×R⁻¹). Latched with in_sig.
- Px_i  in  WIDTH  x coordinate; precondition Px_i < Prime.
- Py_i  in  WIDTH  y coordinate; precondition Py_i < Prime.
- Prime  in  WIDTH  modulus; precondition: odd, ≥ 3. Latched with in_sig.
- Px_out  out  WIDTH  converted x; held until the next done.
- Py_out  out  WIDTH  converted y; held until the next done.
- done  out  1  one-cycle pulse; Px_out/Py_out are valid from this cycle.
- busy  out  1  high from the cycle after in_sig is accepted until done, inclusive.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE; counter = 0.
  - Lane registers, latched Prime, Px_out, Py_out, done and busy are all 0.
  - No partial result is ever emitted after reset.
- States: IDLE → RUN → DONE → IDLE.
- IDLE, in_sig=1 at edge E0: latch Px_i, Py_i, Prime and ToMont; counter = 0; go to RUN. If in_sig=0, stay in IDLE.
- RUN: one iteration per edge on both lanes; counter += 1. After edge WIDTH (counter = WIDTH), go to DONE.
  - Double step (ToMont=1): t = {x,1'b0} (WIDTH+1 bits); x ← (t ≥ p) ? t − p : t.
  - Halve step (ToMont=0): t = x[0] ? x + p : x (WIDTH+1 bits); x ← t >> 1.
  - Both steps keep x < p invariant.
- DONE (edge WIDTH+1): Px_out/Py_out ← lane values; done = 1 for exactly one cycle; busy still high; next state IDLE.
- Latency:
  - done is high in the cycle following edge E0+WIDTH+1.
  - Minimum issue interval is WIDTH+2 cycles.
  - in_sig may be reasserted in the cycle done is high; it is accepted on the next edge (IDLE).
- in_sig while busy: ignored, not queued. Inputs may change freely while busy.
- Px_i = 0 or Py_i = 0 gives 0 in both modes.
- Precondition violations (input ≥ Prime, even Prime) produce undefined data. Handshake timing is unchanged, and the block must not hang.

Optional Feature:
- MDX_RADIX4_EN defined:
  - Two double/halve steps are chained combinationally per edge.
  - RUN lasts WIDTH/2 edges; done comes WIDTH/2+2 cycles after the start edge.
  - Results are identical to the radix-2 mode.
- Undefined: radix-2 only, as described above.

Decomposition:
- Package mdx_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam STEPS_PER_CYC (1 or 2 under MDX_RADIX4_EN).
  - CNT_W derivation helper.
- Sub-module mdx_lane (×2: x and y): holds the lane register, load enable, and the double/halve step logic (1 or 2 cascaded steps). Top level holds the FSM, counter, latched Prime/ToMont and output registers.

Test Plan (WIDTH=32 unless noted):
- Prime=0xFFFFFFFB, ToMont=1, Px=1, Py=2 → Px_out=0x00000005, Py_out=0x0000000A; done pulse exactly 34 cycles after the start edge; busy high for 33 cycles.
- Prime=0xFFFFFFFB, ToMont=0, Px=0x00000005, Py=0xFFFFFFF6 → Px_out=1, Py_out=0xFFFFFFFA.
- Prime=7, ToMont=1, Px=3, Py=0 → Px_out=5, Py_out=0. Feed the result back with ToMont=0 → 3, 0 (round trip).
- in_sig pulsed at cycles 5 and 20 after a start → second pulse ignored; exactly one done; outputs unaffected. in_sig asserted in the done cycle → a new operation starts.
- Reset asserted asynchronously mid-RUN (counter=10) → all outputs 0 immediately; no done; a fresh in_sig afterwards completes correctly.
- WIDTH=8, Prime=251, with and without MDX_RADIX4_EN: ToMont Px=1 → 5. Latency 10 vs 6 cycles; results identical.
